// File: rtl/core_mem_arbiter_pkg.sv
// Shared definitions for the core memory arbiter.
// Holds the job-controller state encoding and the default data/address
// widths used by the arbiter top level.
package core_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_REG_WIDTH  = 12;
    localparam int DEF_ADDR_WIDTH = 12;

endpackage

// File: rtl/core_mem_arbiter_rr_priority_pick.sv
// Combinational round-robin picker.
// Selects at most one eligible requester, searching upward from ptr with
// wrap-around.  A requester is eligible when its req bit is set and its
// mask bit is clear.
// Ports:
//   req   - per-requester request vector
//   mask  - per-requester exclusion vector
//   ptr   - index where the search begins
//   grant - one-hot selected requester (all zero when none)
//   valid - a requester was selected
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    logic [N-1:0]     eligible;
    logic [PTR_W:0]   pos;
    logic [PTR_W-1:0] idx;

    assign eligible = req & ~mask;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        pos   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            // ptr + k, folded back into 0..N-1; one extra bit holds the carry.
            pos = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (pos >= (PTR_W + 1)'(N)) begin
                pos = pos - (PTR_W + 1)'(N);
            end
            idx = pos[PTR_W-1:0];
            if (!valid && eligible[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shared data-memory arbiter and job controller for a cluster of cores.
// A job starts on start (IDLE/DONE -> RUN), pulsing core_start to every core.
// While running, one memory access per cycle is granted round-robin; the
// access is presented to memory one cycle after the request is sampled and
// read data is flagged back one cycle later.  The job ends once every core
// has pulsed core_done.
// Ports:
//   clk, reset         - clock (rising edge) and async active-low reset
//   start              - begin a job (ignored while running)
//   core_req/wr        - per-core access request and direction (1 = write)
//   core_addr/wdata    - packed per-core address and write data
//   core_done          - per-core job-finished pulse
//   mem_q              - memory read data
//   core_gnt           - one-hot grant pulse
//   core_rvalid        - one-hot read-data-valid pulse
//   core_rdata         - read data broadcast to all cores
//   mem_addr/data/wren - memory address, write data, write enable
//   core_start         - job start pulse to all cores
//   all_done           - high while the job is finished
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int CORE_COUNT = 4,
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [CORE_COUNT-1:0]            core_req,
    input  logic [CORE_COUNT-1:0]            core_wr,
    input  logic [CORE_COUNT*ADDR_WIDTH-1:0] core_addr,
    input  logic [CORE_COUNT*REG_WIDTH-1:0]  core_wdata,
    input  logic [CORE_COUNT-1:0]            core_done,
    input  logic [REG_WIDTH-1:0]             mem_q,
    output logic [CORE_COUNT-1:0]            core_gnt,
    output logic [CORE_COUNT-1:0]            core_rvalid,
    output logic [REG_WIDTH-1:0]             core_rdata,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [REG_WIDTH-1:0]             mem_data,
    output logic                             mem_wren,
    output logic [CORE_COUNT-1:0]            core_start,
    output logic                             all_done
);

    localparam int PTR_W = $clog2(CORE_COUNT);

    state_t                  state;
    state_t                  next_state;
    logic                    entering_run;
    logic [CORE_COUNT-1:0]   done_mask;
    logic [CORE_COUNT-1:0]   done_next;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        ptr_next;
    logic [PTR_W-1:0]        gnt_idx;
    logic [CORE_COUNT-1:0]   arb_req;
    logic [CORE_COUNT-1:0]   pick_gnt;
    logic                    pick_valid;
    logic                    sel_wr;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [REG_WIDTH-1:0]    sel_data;

    // Including this cycle's done pulses lets all_done rise the cycle after
    // the last core reports.
    assign done_next = done_mask | core_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)      next_state = RUN;
            RUN:     if (&done_next) next_state = DONE;
            DONE:    if (start)      next_state = RUN;
            default:                 next_state = IDLE;
        endcase
    end

    assign entering_run = (state != RUN) && (next_state == RUN);

    // Requests only compete while a job is running.  The core currently
    // holding core_gnt is masked: it cannot drop req until it sees the grant.
    assign arb_req = (state == RUN) ? core_req : '0;

    rr_priority_pick #(
        .N     (CORE_COUNT),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (arb_req),
        .mask  (core_gnt),
        .ptr   (ptr),
        .grant (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        gnt_idx  = '0;
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (pick_gnt[i]) begin
                gnt_idx  = PTR_W'(i);
                sel_wr   = core_wr[i];
                sel_addr = core_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = core_wdata[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign ptr_next = (gnt_idx == PTR_W'(CORE_COUNT - 1)) ? '0 : gnt_idx + PTR_W'(1);

    // ---- stage boundary: request sample -> grant/memory access ----
    // core_rvalid follows one cycle behind a read grant, so a grant issued in
    // the last RUN cycle still completes after the move to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_gnt    <= '0;
            core_rvalid <= '0;
            core_start  <= '0;
            mem_wren    <= 1'b0;
            all_done    <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            ptr         <= '0;
            done_mask   <= '0;
        end else begin
            core_start <= {CORE_COUNT{entering_run}};
            all_done   <= (next_state == DONE);
            if (entering_run) begin
                done_mask <= '0;
            end else if (state == RUN) begin
                done_mask <= done_next;
            end
            core_gnt <= pick_gnt;
            mem_wren <= pick_valid & sel_wr;
            if (pick_valid) begin
                mem_addr <= sel_addr;
                mem_data <= sel_data;
                ptr      <= ptr_next;
            end
            // ---- stage boundary: memory access -> read data return ----
            core_rvalid <= core_gnt & {CORE_COUNT{~mem_wren}};
        end
    end

    assign core_rdata = mem_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;

    localparam int N  = 4;
    localparam int RW = 12;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [N-1:0]    core_req;
    logic [N-1:0]    core_wr;
    logic [N*AW-1:0] core_addr;
    logic [N*RW-1:0] core_wdata;
    logic [N-1:0]    core_done;
    logic [RW-1:0]   mem_q;
    logic [N-1:0]    core_gnt;
    logic [N-1:0]    core_rvalid;
    logic [RW-1:0]   core_rdata;
    logic [AW-1:0]   mem_addr;
    logic [RW-1:0]   mem_data;
    logic            mem_wren;
    logic [N-1:0]    core_start;
    logic            all_done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          idx;
        logic        wr;
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } gnt_t;

    typedef struct {
        int          idx;
        logic [RW-1:0] data;
    } rd_t;

    gnt_t gq[$];
    rd_t  rq[$];

    core_mem_arbiter #(
        .CORE_COUNT (N),
        .REG_WIDTH  (RW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .core_req    (core_req),
        .core_wr     (core_wr),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_done   (core_done),
        .mem_q       (mem_q),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .core_start  (core_start),
        .all_done    (all_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_core(input int i, input logic wr, input logic [AW-1:0] addr,
                            input logic [RW-1:0] data);
        core_wr[i]              = wr;
        core_addr[i*AW +: AW]   = addr;
        core_wdata[i*RW +: RW]  = data;
        core_req[i]             = 1'b1;
    endtask

    task automatic expect_access(input int i, input logic wr, input logic [AW-1:0] addr,
                                 input logic [RW-1:0] data);
        gnt_t g;
        rd_t  r;
        g.idx = i; g.wr = wr; g.addr = addr; g.data = data;
        gq.push_back(g);
        if (!wr) begin
            r.idx = i; r.data = mem_q;
            rq.push_back(r);
        end
    endtask

    // Advance to the next falling edge and retire any grant / read return
    // the DUT shows there against the scoreboard.
    task automatic step();
        gnt_t g;
        rd_t  r;
        @(negedge clk);
        if (core_gnt !== '0) begin
            if (gq.size() == 0) begin
                chk("sb_unexpected_gnt", 32'(core_gnt), 32'h0);
            end else begin
                g = gq.pop_front();
                chk("sb_gnt", 32'(core_gnt), 32'(onehot(g.idx)));
                chk("sb_wren", 32'(mem_wren), 32'(g.wr));
                chk("sb_addr", 32'(mem_addr), 32'(g.addr));
                if (g.wr) chk("sb_wdata", 32'(mem_data), 32'(g.data));
            end
        end else begin
            chk("sb_idle_wren", 32'(mem_wren), 32'h0);
        end
        if (core_rvalid !== '0) begin
            if (rq.size() == 0) begin
                chk("sb_unexpected_rvalid", 32'(core_rvalid), 32'h0);
            end else begin
                r = rq.pop_front();
                chk("sb_rvalid", 32'(core_rvalid), 32'(onehot(r.idx)));
                chk("sb_rdata", 32'(core_rdata), 32'(r.data));
            end
        end
    endtask

    initial begin
        logic [N-1:0] prev_gnt;

        reset      = 1'b0;
        start      = 1'b0;
        core_req   = '0;
        core_wr    = '0;
        core_done  = '0;
        core_addr  = '0;
        core_wdata = '0;
        mem_q      = 12'hABC;

        // Reset state
        repeat (3) step();
        chk("rst_gnt", 32'(core_gnt), 32'h0);
        chk("rst_rvalid", 32'(core_rvalid), 32'h0);
        chk("rst_start", 32'(core_start), 32'h0);
        chk("rst_wren", 32'(mem_wren), 32'h0);
        chk("rst_all_done", 32'(all_done), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_data", 32'(mem_data), 32'h0);
        reset = 1'b1;

        // Request in IDLE is ignored until a job starts
        set_core(0, 1'b0, 12'h020, 12'h000);
        repeat (3) begin
            step();
            chk("idle_no_gnt", 32'(core_gnt), 32'h0);
        end
        expect_access(0, 1'b0, 12'h020, 12'h000);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_pulse", 32'(core_start), 32'hF);
        chk("gnt_not_yet", 32'(core_gnt), 32'h0);
        step();
        chk("gnt_two_after_start", 32'(core_gnt), 32'h1);
        chk("start_one_cycle", 32'(core_start), 32'h0);
        core_req = '0;
        step();
        chk("idle_req_rvalid", 32'(core_rvalid), 32'h1);

        // Core 2 read; req held through the grant cycle
        set_core(2, 1'b0, 12'h010, 12'h000);
        expect_access(2, 1'b0, 12'h010, 12'h000);
        step();
        chk("rd2_gnt", 32'(core_gnt), 32'h4);
        chk("rd2_addr", 32'(mem_addr), 32'h010);
        chk("rd2_wren", 32'(mem_wren), 32'h0);
        step();
        chk("rd2_no_double_gnt", 32'(core_gnt), 32'h0);
        chk("rd2_rvalid", 32'(core_rvalid), 32'h4);
        chk("rd2_rdata", 32'(core_rdata), 32'hABC);
        core_req = '0;
        step();
        chk("rd2_rvalid_once", 32'(core_rvalid), 32'h0);

        // Core 1 write
        set_core(1, 1'b1, 12'h0FF, 12'h5A5);
        expect_access(1, 1'b1, 12'h0FF, 12'h5A5);
        step();
        chk("wr1_wren", 32'(mem_wren), 32'h1);
        chk("wr1_addr", 32'(mem_addr), 32'h0FF);
        chk("wr1_data", 32'(mem_data), 32'h5A5);
        core_req = '0;
        step();
        chk("wr1_wren_once", 32'(mem_wren), 32'h0);
        chk("wr1_no_rvalid", 32'(core_rvalid), 32'h0);
        chk("wr1_addr_hold", 32'(mem_addr), 32'h0FF);
        chk("wr1_data_hold", 32'(mem_data), 32'h5A5);

        // Core 3 write leaves the pointer at 0
        set_core(3, 1'b1, 12'h333, 12'h3C3);
        expect_access(3, 1'b1, 12'h333, 12'h3C3);
        step();
        chk("wr3_gnt", 32'(core_gnt), 32'h8);
        core_req = '0;
        step();

        // All four cores requesting continuously from ptr = 0
        for (int i = 0; i < N; i++) set_core(i, 1'b0, 12'(12'h100 + i), 12'h000);
        for (int k = 0; k < 5; k++) expect_access(k % N, 1'b0, 12'(12'h100 + (k % N)), 12'h000);
        prev_gnt = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_order", 32'(core_gnt), 32'(onehot(k % N)));
            chk("rr_no_repeat", 32'(core_gnt == prev_gnt), 32'h0);
            prev_gnt = core_gnt;
        end
        core_req = '0;
        step();
        step();

        // Done pulses in order 3,0,2,1; core 2 also requests with its done
        core_done = 4'b1000;
        step();
        core_done = '0;
        chk("done3_not_all", 32'(all_done), 32'h0);
        core_done = 4'b0001;
        step();
        core_done = '0;
        chk("done0_not_all", 32'(all_done), 32'h0);
        core_done = 4'b0100;
        set_core(2, 1'b0, 12'h044, 12'h000);
        expect_access(2, 1'b0, 12'h044, 12'h000);
        step();
        core_done = '0;
        core_req  = '0;
        chk("done2_not_all", 32'(all_done), 32'h0);
        chk("done_and_req_gnt", 32'(core_gnt), 32'h4);
        core_done = 4'b0010;
        set_core(0, 1'b0, 12'h055, 12'h000);
        expect_access(0, 1'b0, 12'h055, 12'h000);
        step();
        core_done = '0;
        core_req  = '0;
        chk("all_done_rise", 32'(all_done), 32'h1);
        chk("final_run_gnt", 32'(core_gnt), 32'h1);
        step();
        chk("final_run_rvalid", 32'(core_rvalid), 32'h1);
        chk("all_done_hold", 32'(all_done), 32'h1);

        // Requests ignored in DONE
        set_core(3, 1'b0, 12'h066, 12'h000);
        step();
        chk("done_no_gnt_a", 32'(core_gnt), 32'h0);
        step();
        chk("done_no_gnt_b", 32'(core_gnt), 32'h0);
        chk("done_still", 32'(all_done), 32'h1);
        core_req = '0;

        // Restart, then a start while running is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_pulse", 32'(core_start), 32'hF);
        chk("restart_clears_done", 32'(all_done), 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run_start_ignored", 32'(core_start), 32'h0);
        step();
        chk("run_start_ignored_b", 32'(core_start), 32'h0);
        chk("mask_cleared", 32'(all_done), 32'h0);

        // Reset asserted while a grant is high
        set_core(1, 1'b1, 12'h0AA, 12'h0BB);
        expect_access(1, 1'b1, 12'h0AA, 12'h0BB);
        step();
        chk("pre_rst_gnt", 32'(core_gnt), 32'h2);
        reset = 1'b0;
        #1;
        chk("arst_gnt", 32'(core_gnt), 32'h0);
        chk("arst_rvalid", 32'(core_rvalid), 32'h0);
        chk("arst_start", 32'(core_start), 32'h0);
        chk("arst_wren", 32'(mem_wren), 32'h0);
        chk("arst_all_done", 32'(all_done), 32'h0);
        chk("arst_addr", 32'(mem_addr), 32'h0);
        chk("arst_data", 32'(mem_data), 32'h0);
        step();
        chk("arst_wren_next", 32'(mem_wren), 32'h0);
        chk("arst_gnt_next", 32'(core_gnt), 32'h0);
        reset = 1'b1;
        step();
        step();
        chk("post_rst_idle_gnt", 32'(core_gnt), 32'h0);
        chk("post_rst_idle_wren", 32'(mem_wren), 32'h0);
        core_req = '0;
        step();

        chk("sb_gnt_drained", 32'(gq.size()), 32'h0);
        chk("sb_rd_drained", 32'(rq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
